// File: rtl/sdc_img_responder.sv
// SD-card block responder: serves 512-byte block reads/writes for two drives
// from disk images held in a byte-wide backing store.
module sdc_img_responder #(
  parameter int MEM_AW = 27
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       sd_lba [2],
  input  logic [1:0]        sd_rd,
  input  logic [1:0]        sd_wr,
  output logic [1:0]        sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din [2],
  input  logic [MEM_AW-1:0] img_base [2],
  input  logic [23:0]       img_blocks [2],
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              xfer_err
);

  typedef enum logic [2:0] {
    IDLE, ACK, RFETCH, RPUT, WADDR, WWAIT, WSTORE, DONE
  } state_t;

  state_t      state;
  logic        drv;
  logic [31:0] lba;
  logic        is_wr;
  logic        oor;
  logic        armed;
  logic [8:0]  idx;
  logic [8:0]  idx_next;

  logic        req_any;
  logic        req_drv;
  logic        req_wr;
  logic        req_oor;

  logic [MEM_AW-1:0] blk_base;
  logic [MEM_AW-1:0] addr_cur;
  logic [MEM_AW-1:0] addr_next;

  // Fixed request priority: rd0, rd1, wr0, wr1.
  always_comb begin
    req_any = 1'b1;
    req_drv = 1'b0;
    req_wr  = 1'b0;
    if (sd_rd[0]) begin
      req_drv = 1'b0;
    end else if (sd_rd[1]) begin
      req_drv = 1'b1;
    end else if (sd_wr[0]) begin
      req_wr = 1'b1;
    end else if (sd_wr[1]) begin
      req_drv = 1'b1;
      req_wr  = 1'b1;
    end else begin
      req_any = 1'b0;
    end
  end

  // Unmounted drives have zero blocks, so they always land out of range.
  assign req_oor = (sd_lba[req_drv][31:24] != 8'd0) ||
                   (sd_lba[req_drv][23:0] >= img_blocks[req_drv]);

  assign idx_next  = idx + 9'd1;
  assign blk_base  = img_base[drv] + MEM_AW'({lba, 9'd0});
  assign addr_cur  = blk_base + MEM_AW'(idx);
  assign addr_next = blk_base + MEM_AW'(idx_next);

  // armed keeps IDLE from accepting on the first edge after reset release.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      armed        <= 1'b0;
      drv          <= 1'b0;
      lba          <= '0;
      is_wr        <= 1'b0;
      oor          <= 1'b0;
      idx          <= '0;
      sd_ack       <= '0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      xfer_err     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && req_any) begin
            drv   <= req_drv;
            lba   <= sd_lba[req_drv];
            is_wr <= req_wr;
            oor   <= req_oor;
            state <= ACK;
          end
        end
        ACK: begin
          sd_ack <= drv ? 2'b10 : 2'b01;
          idx    <= '0;
          if (is_wr) begin
            sd_buff_addr <= '0;
            state        <= WADDR;
          end else begin
            mem_rd <= !oor;
            if (!oor) mem_addr <= blk_base;
            state  <= RFETCH;
          end
        end
        RFETCH: begin
          if (oor || mem_ready) begin
            mem_rd       <= 1'b0;
            sd_buff_addr <= idx;
            sd_buff_dout <= oor ? 8'h00 : mem_rdata;
            sd_buff_wr   <= 1'b1;
            state        <= RPUT;
          end
        end
        RPUT: begin
          sd_buff_wr <= 1'b0;
          if (idx == 9'd511) begin
            sd_ack   <= '0;
            xfer_err <= oor;
            state    <= DONE;
          end else begin
            idx    <= idx_next;
            mem_rd <= !oor;
            if (!oor) mem_addr <= addr_next;
            state  <= RFETCH;
          end
        end
        WADDR: begin
          state <= WWAIT;
        end
        // Initiator buffer data for sd_buff_addr is valid one cycle after WADDR.
        WWAIT: begin
          mem_wdata <= sd_buff_din[drv];
          mem_wr    <= !oor;
          if (!oor) mem_addr <= addr_cur;
          state     <= WSTORE;
        end
        WSTORE: begin
          if (oor || mem_ready) begin
            mem_wr <= 1'b0;
            if (idx == 9'd511) begin
              sd_ack   <= '0;
              xfer_err <= oor;
              state    <= DONE;
            end else begin
              idx          <= idx_next;
              sd_buff_addr <= idx_next;
              state        <= WADDR;
            end
          end
        end
        DONE: begin
          xfer_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_img_responder.sv
// Directed self-checking bench for sdc_img_responder: read, write, range,
// priority, stall and mid-transfer reset scenarios.
module tb_sdc_img_responder;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] sd_lba [2];
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din [2];
  logic [26:0] img_base [2];
  logic [23:0] img_blocks [2];
  logic [26:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b1;
  logic        xfer_err;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [26:0] exp_base = '0;
  logic        exp_zero = 1'b0;
  logic        stall_en = 1'b0;
  int clr_gen = 0;
  int clr_seen = 0;
  int strobe_cnt, bad_strobe, rd_cnt, bad_rd, wr_cnt, bad_wr;
  int err_cnt, ack_bad, overlap, stall_cyc, stall_bad;
  logic chk_ack_low;

  sdc_img_responder #(.MEM_AW(27)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .img_base(img_base), .img_blocks(img_blocks),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .xfer_err(xfer_err)
  );

  always #5 CLK = ~CLK;

  // Backing store holds byte n = n[7:0]; initiator buffer holds ~i, registered.
  assign mem_rdata = mem_addr[7:0];

  always @(posedge CLK) begin
    sd_buff_din[0] <= ~sd_buff_addr[7:0];
    sd_buff_din[1] <= ~sd_buff_addr[7:0];
  end

  // Bus monitor: drives mem_ready and tallies strobes/accesses against the model.
  always @(negedge CLK) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      strobe_cnt = 0; bad_strobe = 0; rd_cnt = 0; bad_rd = 0;
      wr_cnt = 0; bad_wr = 0; err_cnt = 0; ack_bad = 0;
      stall_cyc = 0; stall_bad = 0; chk_ack_low = 1'b0;
    end
    mem_ready = 1'b1;
    if (stall_en && mem_rd && rd_cnt == 100 && stall_cyc < 5) begin
      mem_ready = 1'b0;
      stall_cyc++;
      if (mem_addr != exp_base + 27'd100 || sd_buff_wr || strobe_cnt != 100)
        stall_bad++;
    end
    if (chk_ack_low) begin
      if (sd_ack != 2'b00) ack_bad++;
      chk_ack_low = 1'b0;
    end
    if (sd_buff_wr) begin
      if (sd_buff_addr != 9'(strobe_cnt) ||
          sd_buff_dout != (exp_zero ? 8'h00 : 8'(strobe_cnt)))
        bad_strobe++;
      if (strobe_cnt == 511) begin
        if (sd_ack == 2'b00) ack_bad++;
        chk_ack_low = 1'b1;
      end
      strobe_cnt++;
    end
    if (mem_rd && mem_ready) begin
      if (mem_addr != exp_base + 27'(rd_cnt)) bad_rd++;
      rd_cnt++;
    end
    if (mem_wr && mem_ready) begin
      if (mem_addr != exp_base + 27'(wr_cnt) || mem_wdata != ~8'(wr_cnt)) bad_wr++;
      wr_cnt++;
    end
    if (mem_rd && mem_wr) overlap++;
    if (sd_ack == 2'b11) overlap++;
    if (xfer_err) err_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr);
    sd_rd = rd;
    sd_wr = wr;
  endtask

  task automatic clearCounters();
    clr_gen++;
  endtask

  task automatic waitAck(input logic [1:0] want, input string tag);
    for (int k = 0; k < 100 && sd_ack == 2'b00; k++) @(negedge CLK);
    checkOutput(tag, 64'(sd_ack), 64'(want));
  endtask

  task automatic waitDone(input string tag);
    for (int k = 0; k < 5000 && sd_ack != 2'b00; k++) @(negedge CLK);
    checkOutput(tag, 64'(sd_ack == 2'b00), 64'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic startRead0(input logic [31:0] lba, input logic [26:0] base, input logic zero);
    sd_lba[0] = lba;
    exp_base  = base;
    exp_zero  = zero;
    clearCounters();
    applyStimulus(2'b01, 2'b00);
    @(negedge CLK);
    applyStimulus(2'b00, 2'b00);
  endtask

  initial begin
    RESET_N = 1'b0;
    applyStimulus(2'b00, 2'b00);
    sd_lba[0] = '0; sd_lba[1] = '0;
    img_base[0] = 27'h0;     img_blocks[0] = 24'd4;
    img_base[1] = 27'h10000; img_blocks[1] = 24'd8;
    overlap = 0;
    clearCounters();
    repeat (2) @(negedge CLK);
    checkOutput("reset_outputs",
                64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                     mem_rd, mem_wr, mem_wdata, xfer_err}), 64'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // In-range read of block 2 on drive 0.
    startRead0(32'd2, 27'h400, 1'b0);
    waitAck(2'b01, "rd_ack");
    waitDone("rd_done");
    checkOutput("rd_strobes", 64'(strobe_cnt), 64'd512);
    checkOutput("rd_strobe_bad", 64'(bad_strobe), 64'd0);
    checkOutput("rd_mem_reads", 64'(rd_cnt), 64'd512);
    checkOutput("rd_addr_bad", 64'(bad_rd), 64'd0);
    checkOutput("rd_no_writes", 64'(wr_cnt), 64'd0);
    checkOutput("rd_ack_edges", 64'(ack_bad), 64'd0);
    checkOutput("rd_no_err", 64'(err_cnt), 64'd0);

    // Write of block 0 on drive 1.
    sd_lba[1] = 32'd0; exp_base = 27'h10000;
    clearCounters();
    applyStimulus(2'b00, 2'b10);
    @(negedge CLK);
    applyStimulus(2'b00, 2'b00);
    waitAck(2'b10, "wr_ack");
    waitDone("wr_done");
    checkOutput("wr_mem_writes", 64'(wr_cnt), 64'd512);
    checkOutput("wr_data_bad", 64'(bad_wr), 64'd0);
    checkOutput("wr_no_strobes", 64'(strobe_cnt), 64'd0);
    checkOutput("wr_no_reads", 64'(rd_cnt), 64'd0);
    checkOutput("wr_no_err", 64'(err_cnt), 64'd0);

    // Read one block past the image end.
    startRead0(32'd4, 27'h800, 1'b1);
    waitAck(2'b01, "oor_rd_ack");
    waitDone("oor_rd_done");
    checkOutput("oor_rd_strobes", 64'(strobe_cnt), 64'd512);
    checkOutput("oor_rd_zero_data", 64'(bad_strobe), 64'd0);
    checkOutput("oor_rd_no_mem", 64'(rd_cnt), 64'd0);
    checkOutput("oor_rd_err_pulse", 64'(err_cnt), 64'd1);

    // Write with nonzero upper LBA bits on drive 1.
    sd_lba[1] = 32'h0100_0000;
    clearCounters();
    applyStimulus(2'b00, 2'b10);
    @(negedge CLK);
    applyStimulus(2'b00, 2'b00);
    waitAck(2'b10, "oor_wr_ack");
    waitDone("oor_wr_done");
    checkOutput("oor_wr_no_mem", 64'(wr_cnt), 64'd0);
    checkOutput("oor_wr_no_strobe", 64'(strobe_cnt), 64'd0);
    checkOutput("oor_wr_err_pulse", 64'(err_cnt), 64'd1);

    // Drive-1 read and drive-0 write requested together.
    sd_lba[1] = 32'd0; sd_lba[0] = 32'd1;
    exp_base = 27'h10000; exp_zero = 1'b0;
    clearCounters();
    applyStimulus(2'b10, 2'b01);
    waitAck(2'b10, "prio_first_ack");
    applyStimulus(2'b00, 2'b01);
    waitDone("prio_first_done");
    checkOutput("prio_rd_strobes", 64'(strobe_cnt), 64'd512);
    checkOutput("prio_rd_data_bad", 64'(bad_strobe), 64'd0);
    checkOutput("prio_rd_addr_bad", 64'(bad_rd), 64'd0);
    checkOutput("prio_rd_no_writes", 64'(wr_cnt), 64'd0);
    exp_base = 27'h200;
    clearCounters();
    waitAck(2'b01, "prio_second_ack");
    applyStimulus(2'b00, 2'b00);
    waitDone("prio_second_done");
    checkOutput("prio_wr_writes", 64'(wr_cnt), 64'd512);
    checkOutput("prio_wr_data_bad", 64'(bad_wr), 64'd0);
    checkOutput("prio_wr_no_strobes", 64'(strobe_cnt), 64'd0);

    // Five-cycle memory stall on byte 100 of the last valid block.
    stall_en = 1'b1;
    startRead0(32'd3, 27'h600, 1'b0);
    waitAck(2'b01, "stall_ack");
    waitDone("stall_done");
    stall_en = 1'b0;
    checkOutput("stall_cycles", 64'(stall_cyc), 64'd5);
    checkOutput("stall_hold_bad", 64'(stall_bad), 64'd0);
    checkOutput("stall_strobes", 64'(strobe_cnt), 64'd512);
    checkOutput("stall_data_bad", 64'(bad_strobe), 64'd0);
    checkOutput("stall_addr_bad", 64'(bad_rd), 64'd0);

    // Reset asserted around byte 300, then a fresh read.
    startRead0(32'd2, 27'h400, 1'b0);
    for (int k = 0; k < 3000 && strobe_cnt < 300; k++) @(negedge CLK);
    checkOutput("rst_reached_300", 64'(strobe_cnt), 64'd300);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("rst_mid_outputs",
                64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                     mem_rd, mem_wr, mem_wdata, xfer_err}), 64'd0);
    repeat (3) @(negedge CLK);
    checkOutput("rst_no_more_strobes", 64'(strobe_cnt), 64'd300);
    RESET_N = 1'b1;
    clearCounters();
    applyStimulus(2'b01, 2'b00);
    @(negedge CLK);
    checkOutput("rst_arm_edge1", 64'(sd_ack), 64'd0);
    @(negedge CLK);
    checkOutput("rst_arm_edge2", 64'(sd_ack), 64'd0);
    @(negedge CLK);
    checkOutput("rst_arm_edge3", 64'(sd_ack), 64'd1);
    applyStimulus(2'b00, 2'b00);
    waitDone("rst_redo_done");
    checkOutput("rst_redo_strobes", 64'(strobe_cnt), 64'd512);
    checkOutput("rst_redo_data_bad", 64'(bad_strobe), 64'd0);
    checkOutput("rst_redo_addr_bad", 64'(bad_rd), 64'd0);

    checkOutput("no_overlap", 64'(overlap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
